// File: rtl/reg_file_mp_pkg.sv
// Shared constants for the multi-port register file: the addresses of the
// memory-mapped registers and the reset value of every storage word.
package rf_pkg;

   // UART state, overlaid on reads
   localparam int unsigned US   = 26;
   // Timer counter, overlaid on reads
   localparam int unsigned TMR  = 27;
   // Timer control, exported as tmr_ctrl
   localparam int unsigned TCON = 28;
   // Result register, low byte exported as leds
   localparam int unsigned V0   = 2;

   localparam int unsigned RST_VAL = 0;

endpackage

// File: rtl/reg_file_mp_if.sv
// Handshaked peripheral write port of the register file. A peripheral
// (master) offers one address/data pair per cycle. The register file
// (slave) takes it on any edge where per_valid and per_ready are both high.
interface reg_file_mp_if #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
);
   logic              per_valid;
   logic [ADDR_W-1:0] per_wa;
   logic [DATA_W-1:0] per_wd;
   logic              per_ready;

   modport master (output per_valid, per_wa, per_wd, input per_ready);
   modport slave  (input per_valid, per_wa, per_wd, output per_ready);
endinterface

// File: rtl/reg_file_mp_wr_arb.sv
// Peripheral write arbiter. It detects collisions with the CPU write port,
// parks a colliding peripheral write in a one-entry pending buffer, generates
// a registered per_ready, and presents a single commit (valid/addr/data) to
// the array. Because per_ready is low while an entry is pending, the pending
// commit and a fresh peripheral accept can never occur in the same cycle.
module rf_wr_arb
   import rf_pkg::*;
#(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] wa,
   input  logic              per_valid,
   input  logic [ADDR_W-1:0] per_wa,
   input  logic [DATA_W-1:0] per_wd,
   output logic              per_ready,
   output logic              cmt_valid,
   output logic [ADDR_W-1:0] cmt_addr,
   output logic [DATA_W-1:0] cmt_data
);

   logic              pend_valid;
   logic [ADDR_W-1:0] pend_addr;
   logic [DATA_W-1:0] pend_data;
   logic              ready_q;

   logic accept;
   logic conflict;
   logic pend_commit;

   assign accept   = per_valid & ready_q;
   // Only a real CPU write (non-zero address) to the same word collides.
   assign conflict = accept & we & (wa != '0) & (per_wa == wa);
   // The pending entry waits while the CPU keeps writing its address.
   assign pend_commit = pend_valid & ~(we & (wa == pend_addr));

   assign per_ready = ready_q;

   // Select the single peripheral-side commit for this edge.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      cmt_valid = 1'b0;
      cmt_addr  = '0;
      cmt_data  = '0;
      if (pend_commit) begin
         cmt_valid = 1'b1;
         cmt_addr  = pend_addr;
         cmt_data  = pend_data;
      end else if (accept && !conflict && per_wa != '0) begin
         cmt_valid = 1'b1;
         cmt_addr  = per_wa;
         cmt_data  = per_wd;
      end
   end

   // Pending buffer and registered ready: park on conflict, release on commit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
         pend_valid <= 1'b0;
         pend_addr  <= '0;
         pend_data  <= DATA_W'(RST_VAL);
         ready_q    <= 1'b1;
      end else if (conflict) begin
         pend_valid <= 1'b1;
         pend_addr  <= per_wa;
         pend_data  <= per_wd;
         ready_q    <= 1'b0;
      end else if (pend_commit) begin
         pend_valid <= 1'b0;
         ready_q    <= 1'b1;
      end
   end

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised multi-port register file for the single-cycle MIPS core.
// NUM_RD combinational read ports, a CPU write port and a handshaked
// peripheral write port. Register 0 is hardwired to zero, and the US/TMR
// addresses read back live peripheral state.
// Build option: define RF_BYPASS_EN to forward same-cycle write data to reads.
module reg_file_mp
   import rf_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NUM_RD = 2,
   parameter int US_W   = 4,
   parameter int TC_W   = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_RD*ADDR_W-1:0] ra,
   output logic [NUM_RD*DATA_W-1:0] rd,
   input  logic                     we,
   input  logic [ADDR_W-1:0]        wa,
   input  logic [DATA_W-1:0]        wd,
   reg_file_mp_if.slave             per,
   input  logic [US_W-1:0]          us,
   input  logic [TC_W-1:0]          tmr_cntr,
   output logic [DATA_W-1:0]        tmr_ctrl,
   output logic [7:0]               leds
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] A_US   = ADDR_W'(US);
   localparam logic [ADDR_W-1:0] A_TMR  = ADDR_W'(TMR);
   localparam logic [ADDR_W-1:0] A_TCON = ADDR_W'(TCON);
   localparam logic [ADDR_W-1:0] A_V0   = ADDR_W'(V0);

   logic [DATA_W-1:0] regs [DEPTH];

   logic              cmt_valid;
   logic [ADDR_W-1:0] cmt_addr;
   logic [DATA_W-1:0] cmt_data;
   logic              cpu_wr;

   assign cpu_wr = we & (wa != '0);

   rf_wr_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_wr_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .we        (we),
      .wa        (wa),
      .per_valid (per.per_valid),
      .per_wa    (per.per_wa),
      .per_wd    (per.per_wd),
      .per_ready (per.per_ready),
      .cmt_valid (cmt_valid),
      .cmt_addr  (cmt_addr),
      .cmt_data  (cmt_data)
   );

   // Storage: CPU write first, then peripheral commit (the arbiter never lets both hit one word).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the whole array is reset because software relies on every register reading 0 after reset; this forces flops rather than RAM.
         for (int i = 0; i < DEPTH; i++) regs[i] <= DATA_W'(RST_VAL);
      end else begin
         if (cpu_wr)    regs[wa]       <= wd;
         if (cmt_valid) regs[cmt_addr] <= cmt_data;
      end
   end

   assign tmr_ctrl = regs[A_TCON];
   assign leds     = regs[A_V0][7:0];

   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] v;
      assign a = ra[k*ADDR_W +: ADDR_W];
      assign rd[k*DATA_W +: DATA_W] = v;

      // Read mux: zero register and overlays first, then forwarding, then storage.
      always_comb begin
         v = regs[a];
         if (a == '0)
            v = '0;
         else if (a == A_US)
            v = DATA_W'(us);
         else if (a == A_TMR)
            v = DATA_W'(tmr_cntr);
`ifdef RF_BYPASS_EN
         else if (cpu_wr && wa == a)
            v = wd;
         else if (cmt_valid && cmt_addr == a)
            v = cmt_data;
`endif
      end
   end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed self-checking bench for reg_file_mp (2 read ports, 32x32).
// Expected values are hand-computed; reads are checked 1 ns after a clock
// edge, once the combinational paths have settled.
module tb_reg_file_mp;
   import rf_pkg::*;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [9:0]  ra;
   logic [63:0] rd;
   logic        we;
   logic [4:0]  wa;
   logic [31:0] wd;
   logic [3:0]  us;
   logic [15:0] tmr_cntr;
   logic [31:0] tmr_ctrl;
   logic [7:0]  leds;

   int checks   = 0;
   int failures = 0;

   reg_file_mp_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) pif ();

   reg_file_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(2), .US_W(4), .TC_W(16)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .ra       (ra),
      .rd       (rd),
      .we       (we),
      .wa       (wa),
      .wd       (wd),
      .per      (pif),
      .us       (us),
      .tmr_cntr (tmr_cntr),
      .tmr_ctrl (tmr_ctrl),
      .leds     (leds)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ra(input logic [4:0] a0, input logic [4:0] a1);
      ra = {a1, a0};
      #1;
   endtask

   task automatic cpu(input logic en, input logic [4:0] a, input logic [31:0] d);
      we = en;
      wa = a;
      wd = d;
   endtask

   task automatic per_req(input logic v, input logic [4:0] a, input logic [31:0] d);
      pif.per_valid = v;
      pif.per_wa    = a;
      pif.per_wd    = d;
   endtask

   initial begin
      rst_n    = 1'b1;
      ra       = '0;
      us       = 4'hA;
      tmr_cntr = 16'h1234;
      cpu(1'b0, 5'd0, 32'h0);
      per_req(1'b0, 5'd0, 32'h0);

      // Asynchronous reset asserted mid-cycle
      #2 rst_n = 1'b0;
      set_ra(5'd5, 5'd6);
      check("rst_rd0", rd[31:0], 32'h0);
      check("rst_rd1", rd[63:32], 32'h0);
      check("rst_tmr_ctrl", tmr_ctrl, 32'h0);
      check("rst_leds", {24'h0, leds}, 32'h0);
      check("rst_per_ready", {31'h0, pif.per_ready}, 32'h1);
      @(negedge clk) rst_n = 1'b1;

      // CPU write then readback
      cpu(1'b1, 5'd5, 32'hDEADBEEF);
      set_ra(5'd5, 5'd0);
`ifdef RF_BYPASS_EN
      check("wr5_same_cycle", rd[31:0], 32'hDEADBEEF);
`else
      check("wr5_same_cycle", rd[31:0], 32'h0);
`endif
      tick();
      cpu(1'b0, 5'd0, 32'h0);
      set_ra(5'd5, 5'd0);
      check("wr5_rd0", rd[31:0], 32'hDEADBEEF);
      check("wr5_rd1_zero", rd[63:32], 32'h0);

      // Write to register 0 is discarded
      cpu(1'b1, 5'd0, 32'hFFFF_FFFF);
      tick();
      cpu(1'b0, 5'd0, 32'h0);
      set_ra(5'd0, 5'd5);
      check("r0_zero", rd[31:0], 32'h0);
      check("r5_kept", rd[63:32], 32'hDEADBEEF);

      // Overlays on each port, then swapped
      set_ra(5'(US), 5'(TMR));
      check("ovl_us_p0", rd[31:0], 32'h0000_000A);
      check("ovl_tmr_p1", rd[63:32], 32'h0000_1234);
      set_ra(5'(TMR), 5'(US));
      check("ovl_tmr_p0", rd[31:0], 32'h0000_1234);
      check("ovl_us_p1", rd[63:32], 32'h0000_000A);

      // Storage write to TMR stays hidden behind the overlay
      cpu(1'b1, 5'(TMR), 32'h0000_0077);
      tick();
      cpu(1'b0, 5'd0, 32'h0);
      set_ra(5'(TMR), 5'd0);
      check("tmr_hidden", rd[31:0], 32'h0000_1234);

      // Single conflict on register 8
      cpu(1'b1, 5'd8, 32'h1);
      per_req(1'b1, 5'd8, 32'h2);
      set_ra(5'd8, 5'd0);
      check("cf_ready_before", {31'h0, pif.per_ready}, 32'h1);
      tick();
      cpu(1'b0, 5'd0, 32'h0);
      per_req(1'b0, 5'd0, 32'h0);
      set_ra(5'd8, 5'd0);
      check("cf_ready_low", {31'h0, pif.per_ready}, 32'h0);
`ifdef RF_BYPASS_EN
      check("cf_reg8_cpu", rd[31:0], 32'h2);
`else
      check("cf_reg8_cpu", rd[31:0], 32'h1);
`endif
      tick();
      set_ra(5'd8, 5'd0);
      check("cf_reg8_per", rd[31:0], 32'h2);
      check("cf_ready_back", {31'h0, pif.per_ready}, 32'h1);

      // Peripheral and CPU write different registers on the same edge
      cpu(1'b1, 5'd10, 32'hAA);
      per_req(1'b1, 5'd9, 32'h99);
      tick();
      cpu(1'b0, 5'd0, 32'h0);
      per_req(1'b0, 5'd0, 32'h0);
      set_ra(5'd9, 5'd10);
      check("nc_reg9", rd[31:0], 32'h99);
      check("nc_reg10", rd[63:32], 32'hAA);
      check("nc_ready", {31'h0, pif.per_ready}, 32'h1);

      // Same-cycle read of a CPU write to V0, then leds
      cpu(1'b1, 5'(V0), 32'h55);
      set_ra(5'(V0), 5'd0);
`ifdef RF_BYPASS_EN
      check("byp_v0", rd[31:0], 32'h55);
`else
      check("byp_v0", rd[31:0], 32'h0);
`endif
      check("leds_pre", {24'h0, leds}, 32'h0);
      tick();
      cpu(1'b0, 5'd0, 32'h0);
      set_ra(5'(V0), 5'd0);
      check("leds_post", {24'h0, leds}, 32'h55);
      check("v0_post", rd[31:0], 32'h55);

      // TCON export
      cpu(1'b1, 5'(TCON), 32'h0000_00C3);
      tick();
      cpu(1'b0, 5'd0, 32'h0);
      check("tmr_ctrl", tmr_ctrl, 32'h0000_00C3);

      // Repeated conflict: pending entry held across three CPU writes to reg 8
      set_ra(5'd11, 5'd0);
      cpu(1'b1, 5'd8, 32'h11);
      per_req(1'b1, 5'd8, 32'h22);
      tick();
      per_req(1'b0, 5'd0, 32'h0);
      cpu(1'b1, 5'd8, 32'h12);
      set_ra(5'd8, 5'd0);
`ifdef RF_BYPASS_EN
      check("rc_reg8_a", rd[31:0], 32'h12);
`else
      check("rc_reg8_a", rd[31:0], 32'h11);
`endif
      check("rc_ready_a", {31'h0, pif.per_ready}, 32'h0);
      tick();
      cpu(1'b1, 5'd8, 32'h13);
      #1;
      check("rc_ready_b", {31'h0, pif.per_ready}, 32'h0);
      tick();
      cpu(1'b0, 5'd0, 32'h0);
      set_ra(5'd8, 5'd0);
`ifdef RF_BYPASS_EN
      check("rc_reg8_c", rd[31:0], 32'h22);
`else
      check("rc_reg8_c", rd[31:0], 32'h13);
`endif
      check("rc_ready_c", {31'h0, pif.per_ready}, 32'h0);
      tick();
      set_ra(5'd8, 5'd0);
      check("rc_reg8_final", rd[31:0], 32'h22);
      check("rc_ready_final", {31'h0, pif.per_ready}, 32'h1);

      // Reset while a peripheral write is pending drops it
      cpu(1'b1, 5'd12, 32'h5);
      per_req(1'b1, 5'd12, 32'h6);
      tick();
      cpu(1'b0, 5'd0, 32'h0);
      per_req(1'b0, 5'd0, 32'h0);
      check("mr_ready_low", {31'h0, pif.per_ready}, 32'h0);
      #2 rst_n = 1'b0;
      set_ra(5'd12, 5'(V0));
      check("mr_ready", {31'h0, pif.per_ready}, 32'h1);
      check("mr_reg12", rd[31:0], 32'h0);
      check("mr_v0", rd[63:32], 32'h0);
      check("mr_leds", {24'h0, leds}, 32'h0);
      check("mr_tmr_ctrl", tmr_ctrl, 32'h0);
      @(negedge clk) rst_n = 1'b1;
      tick();
      tick();
      set_ra(5'd12, 5'd0);
      check("mr_dropped", rd[31:0], 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
Parametrised multi-port register file for the single-cycle MIPS core. Successor to the fixed 2-read/1-write file:
- configurable data width, depth and read-port count;
- hardwired-zero register;
- async active-low reset;
- per-port peripheral read overlays (UART state, timer counter);
- second, handshaked write port so peripherals (UART RX, timer) can deposit values without stalling the CPU;
- exports the timer control register and LED register as before.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- NUM_RD, 2, number of combinational read ports (1..4)
- US_W, 4, UART state width, zero-extended on read
- TC_W, 16, timer counter width, zero-extended on read

Ports:
- clk  in  1  core clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- ra  in  NUM_RD*ADDR_W  packed read addresses, port k at [k*ADDR_W +: ADDR_W]
- rd  out  NUM_RD*DATA_W  packed read data, port k at [k*DATA_W +: DATA_W]
- we  in  1  CPU write enable
- wa  in  ADDR_W  CPU write address
- wd  in  DATA_W  CPU write data
- per_valid  in  1  peripheral write request
- per_wa  in  ADDR_W  peripheral write address
- per_wd  in  DATA_W  peripheral write data
- per_ready  out  1  peripheral write accepted this cycle when high with per_valid
- us  in  US_W  UART state, overlaid on reads of US address
- tmr_cntr  in  TC_W  timer counter, overlaid on reads of TMR address
- tmr_ctrl  out  DATA_W  contents of TCON register
- leds  out  8  bits [7:0] of V0 register

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-low (clk, rst_n). Reset clears every register to 0, clears the pending buffer, and drives tmr_ctrl=0, leds=0, per_ready=1. Reset mid-transaction drops any pending peripheral write.
- Read (combinational, per port k, evaluated independently on its own address):
  - address 0 -> 0;
  - US -> zero-extended us;
  - TMR -> zero-extended tmr_cntr;
  - else bypass path (see Optional Feature), else array contents.
- CPU write: commits on rising edge when we=1 and wa!=0. Zero latency; no handshake.
- Peripheral write, handshake accept = per_valid & per_ready.
  - Accepted with no address conflict (per_wa != wa or we=0): commits same edge.
  - Accepted with we=1 and per_wa==wa: CPU data commits; peripheral entry is parked in a one-entry pending buffer. per_ready=0 from the next cycle.
  - Pending entry commits on the first later edge where the CPU is not writing the same address. per_ready returns to 1 the cycle after the commit. Final value = peripheral data (peripheral logically ordered after CPU).
  - per_ready is a registered, combinational-free output.
- Writes to address 0 are discarded from either source. Writes to US/TMR update storage but stay hidden by the overlay.
- tmr_ctrl and leds reflect register state (post-edge), never bypass data.

Optional Feature:
RF_BYPASS_EN.
- Defined: a read whose address matches a same-cycle committing write returns that write's data. Priority: CPU write, then pending commit, then accepted peripheral write.
- Undefined: reads return pre-edge array contents; new value is visible the cycle after commit.
- Overlays and register 0 take precedence in both builds.

Decomposition:
- Shared include/package rf_pkg: register address constants US, TMR, TCON, V0; reset value 0.
- One sub-module, rf_wr_arb: pending buffer, per_ready generation, conflict detect. Outputs one muxed peripheral commit (valid/addr/data) to the array.

Test Plan:
- Reset: drive rst_n=0 mid-cycle -> rd all 0, tmr_ctrl=0, leds=0, per_ready=1 immediately (async).
- CPU write/readback: we=1, wa=5, wd=0xDEADBEEF; next cycle ra0=5, ra1=0 -> rd0=0xDEADBEEF, rd1=0. Write to address 0 -> still reads 0.
- Overlay per port: us=4'hA, tmr_cntr=16'h1234; ra0=US, ra1=TMR -> rd0=0x0000000A, rd1=0x00001234. Swap ports -> swapped results.
- Conflict: same edge we=1, wa=8, wd=1 and per_valid, per_wa=8, per_wd=2 -> per_ready=0 next cycle; reg8=1 then =2 one edge later; per_ready=1 after that.
- Bypass (RF_BYPASS_EN): we=1, wa=V0, wd=0x55, ra0=V0 same cycle -> rd0=0x55; leds=0x55 after edge. Without macro -> rd0 shows old value that cycle.
- Repeated conflict: CPU writes reg8 three consecutive cycles with pending entry to 8 -> pending held all three; commits on fourth edge.
